// File: rtl/ehgu_ram_arb_pkg.sv
// Shared request-class type and round-robin pointer helper for ehgu_ram_arbiter.
package ehgu_ram_arb_pkg;

    typedef enum logic {
        REQ_RD = 1'b0,
        REQ_WR = 1'b1
    } req_kind_e;

    // Priority pointer after a grant to requester ptr, wrapping at nreq.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned nreq);
        int unsigned nxt;
        if (ptr + 32'd1 >= nreq) begin
            nxt = 32'd0;
        end else begin
            nxt = ptr + 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/ehgu_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from a request vector; the priority
// pointer advances past the winner only when en commits the grant.
module ehgu_rr_arbiter
    import ehgu_ram_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   grant_idx,
    output logic            grant_any
);

    logic [PW-1:0] ptr_r;

    // Scan requesters starting at the pointer; first one found wins.
    always_comb begin
        logic [PW-1:0] cand;
        cand      = '0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            cand = PW'((32'(ptr_r) + 32'(i)) % 32'(NREQ));
            if (req[cand] && !grant_any) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                grant_any   = 1'b1;
            end else begin
                grant_any = grant_any;
            end
        end
    end

    // Priority pointer: moves to winner+1 on a committed grant, else holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (en && grant_any) begin
            ptr_r <= PW'(rr_next(32'(grant_idx), 32'(NREQ)));
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/ehgu_ram_arbiter.sv
// Shares one 1W/1R RAM among NREQ requesters with independent write/read
// round-robin. Optional macro EHGU_RAM_ARB_FWD_EN forwards write data to a
// same-cycle same-address read instead of stalling that read.
module ehgu_ram_arbiter
    import ehgu_ram_arb_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int NREQ  = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [NREQ-1:0]               req_we,
    input  logic [NREQ*$clog2(DEPTH)-1:0] req_addr,
    input  logic [NREQ*WIDTH-1:0]         req_wdata,
    output logic [NREQ-1:0]               req_ready,
    output logic [NREQ-1:0]               rsp_valid,
    output logic [WIDTH-1:0]              rsp_data,
    output logic                          ram_wenable,
    output logic [$clog2(DEPTH)-1:0]      ram_waddr,
    output logic [WIDTH-1:0]              ram_wdata,
    output logic                          ram_renable,
    output logic [$clog2(DEPTH)-1:0]      ram_raddr,
    input  logic [WIDTH-1:0]              ram_rdata
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]  wr_req_s, rd_req_s, wgnt_s, rgnt_s;
    logic [PW-1:0]    widx_s, ridx_s, rsp_idx_r;
    logic             wany_s, rany_s, hazard_s, rd_fire_s, ren_s, rsp_pend_r;
    logic [AW-1:0]    waddr_s, raddr_s;
    logic [WIDTH-1:0] wdata_s;

    // Split valid requests into write and read classes.
    always_comb begin
        wr_req_s = '0;
        rd_req_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i]) begin
                if (req_kind_e'(req_we[i]) == REQ_WR) begin
                    wr_req_s[i] = 1'b1;
                end else begin
                    rd_req_s[i] = 1'b1;
                end
            end else begin
                wr_req_s[i] = 1'b0;
            end
        end
    end

    ehgu_rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_warb (
        .clk(clk), .rst_n(rst_n), .en(1'b1), .req(wr_req_s),
        .grant(wgnt_s), .grant_idx(widx_s), .grant_any(wany_s)
    );

    ehgu_rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rarb (
        .clk(clk), .rst_n(rst_n), .en(rd_fire_s), .req(rd_req_s),
        .grant(rgnt_s), .grant_idx(ridx_s), .grant_any(rany_s)
    );

    // Winner address/data selection and read/write hazard resolution.
    always_comb begin
        waddr_s  = req_addr[32'(widx_s)*AW +: AW];
        raddr_s  = req_addr[32'(ridx_s)*AW +: AW];
        wdata_s  = req_wdata[32'(widx_s)*WIDTH +: WIDTH];
        hazard_s = wany_s && rany_s && (raddr_s == waddr_s);
`ifdef EHGU_RAM_ARB_FWD_EN
        rd_fire_s = rany_s;
        ren_s     = rany_s && !hazard_s;
`else
        rd_fire_s = rany_s && !hazard_s;
        ren_s     = rd_fire_s;
`endif
    end

    assign req_ready   = wgnt_s | (rd_fire_s ? rgnt_s : {NREQ{1'b0}});
    assign ram_wenable = wany_s;
    assign ram_waddr   = wany_s ? waddr_s : {AW{1'b0}};
    assign ram_wdata   = wany_s ? wdata_s : {WIDTH{1'b0}};
    assign ram_renable = ren_s;
    assign ram_raddr   = ren_s ? raddr_s : {AW{1'b0}};

    // Response pipeline: remember which requester's read is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_pend_r <= 1'b0;
            rsp_idx_r  <= '0;
        end else begin
            rsp_pend_r <= rd_fire_s;
            rsp_idx_r  <= rd_fire_s ? ridx_s : {PW{1'b0}};
        end
    end

    // One-hot response strobe towards the requester that won the read.
    always_comb begin
        rsp_valid = '0;
        if (rsp_pend_r) begin
            rsp_valid[rsp_idx_r] = 1'b1;
        end else begin
            rsp_valid = '0;
        end
    end

`ifdef EHGU_RAM_ARB_FWD_EN
    logic             fwd_sel_r;
    logic [WIDTH-1:0] fwd_data_r;

    // Forward register: a hazard read returns the colliding write's data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_sel_r  <= 1'b0;
            fwd_data_r <= '0;
        end else begin
            fwd_sel_r  <= hazard_s;
            fwd_data_r <= hazard_s ? wdata_s : fwd_data_r;
        end
    end

    assign rsp_data = fwd_sel_r ? fwd_data_r : ram_rdata;
`else
    assign rsp_data = ram_rdata;
`endif

endmodule

// File: tb/tb_ehgu_ram_arbiter.sv
// Directed, table-driven bench for ehgu_ram_arbiter (NREQ=2 main DUT plus an
// NREQ=4 instance for the 4-way rotation). Honors EHGU_RAM_ARB_FWD_EN.
module tb_ehgu_ram_arbiter;

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  we;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [1:0]  ready;
        logic [1:0]  rsp;
        logic [7:0]  rdata;
        logic        wen;
        logic [3:0]  waddr;
        logic [7:0]  wd;
        logic        ren;
        logic [3:0]  raddr;
    } vec_t;

    logic        clk, rst_n;
    logic [1:0]  req_valid, req_we, req_ready, rsp_valid;
    logic [7:0]  req_addr, rsp_data, ram_wdata, ram_rdata;
    logic [15:0] req_wdata;
    logic        ram_wenable, ram_renable;
    logic [3:0]  ram_waddr, ram_raddr;
    logic [7:0]  mem [16];

    logic [3:0]  req_valid4, req_we4, req_ready4, rsp_valid4;
    logic [15:0] req_addr4;
    logic [31:0] req_wdata4;
    logic [7:0]  rsp_data4, ram_wdata4, ram_rdata4;
    logic        ram_wenable4, ram_renable4;
    logic [3:0]  ram_waddr4, ram_raddr4;

    int total = 0;
    int bad   = 0;
    vec_t vt [19];

    ehgu_ram_arbiter #(.DEPTH(16), .WIDTH(8), .NREQ(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .ram_wenable(ram_wenable),
        .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_renable(ram_renable),
        .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
    );

    ehgu_ram_arbiter #(.DEPTH(16), .WIDTH(8), .NREQ(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid4), .req_we(req_we4),
        .req_addr(req_addr4), .req_wdata(req_wdata4), .req_ready(req_ready4),
        .rsp_valid(rsp_valid4), .rsp_data(rsp_data4), .ram_wenable(ram_wenable4),
        .ram_waddr(ram_waddr4), .ram_wdata(ram_wdata4), .ram_renable(ram_renable4),
        .ram_raddr(ram_raddr4), .ram_rdata(ram_rdata4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models: registered read, read-before-write on the same edge.
    always @(posedge clk) begin
        if (ram_wenable) mem[ram_waddr] <= ram_wdata;
        if (ram_renable) ram_rdata <= mem[ram_raddr];
        if (ram_renable4) ram_rdata4 <= {4'hC, ram_raddr4};
    end

    function automatic vec_t mk(input logic [1:0] valid, input logic [1:0] we,
                                input logic [7:0] addr, input logic [15:0] wdata,
                                input logic [1:0] ready, input logic [1:0] rsp,
                                input logic [7:0] rdata, input logic wen,
                                input logic [3:0] waddr, input logic [7:0] wd,
                                input logic ren, input logic [3:0] raddr);
        vec_t v;
        v.valid = valid; v.we = we; v.addr = addr; v.wdata = wdata;
        v.ready = ready; v.rsp = rsp; v.rdata = rdata; v.wen = wen;
        v.waddr = waddr; v.wd = wd; v.ren = ren; v.raddr = raddr;
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row=%0d actual=%0h required=%0h", nm, row, act, exp);
        end
    endtask

    task automatic check_vec(input vec_t v, input int row);
        chk("req_ready", row, 32'(req_ready), 32'(v.ready));
        chk("rsp_valid", row, 32'(rsp_valid), 32'(v.rsp));
        if (v.rsp != 2'b00) chk("rsp_data", row, 32'(rsp_data), 32'(v.rdata));
        chk("ram_wenable", row, 32'(ram_wenable), 32'(v.wen));
        chk("ram_waddr", row, 32'(ram_waddr), 32'(v.waddr));
        chk("ram_wdata", row, 32'(ram_wdata), 32'(v.wd));
        chk("ram_renable", row, 32'(ram_renable), 32'(v.ren));
        chk("ram_raddr", row, 32'(ram_raddr), 32'(v.raddr));
    endtask

    task automatic apply_vec(input vec_t v, input int row);
        req_valid = v.valid; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
        @(negedge clk);
        check_vec(v, row);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog row=0 actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          valid  we     addr   wdata     ready  rsp    rdata  wen   waddr wd     ren   raddr
        vt[0]  = mk(2'b00, 2'b00, 8'h00, 16'h0000, 2'b00, 2'b00, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0);
        vt[1]  = mk(2'b10, 2'b10, 8'h70, 16'h7700, 2'b10, 2'b00, 8'h00, 1'b1, 4'h7, 8'h77, 1'b0, 4'h0);
        vt[2]  = mk(2'b10, 2'b10, 8'h40, 16'h0000, 2'b10, 2'b00, 8'h00, 1'b1, 4'h4, 8'h00, 1'b0, 4'h0);
        vt[3]  = mk(2'b11, 2'b11, 8'h21, 16'h2010, 2'b01, 2'b00, 8'h00, 1'b1, 4'h1, 8'h10, 1'b0, 4'h0);
        vt[4]  = mk(2'b11, 2'b11, 8'h21, 16'h2010, 2'b10, 2'b00, 8'h00, 1'b1, 4'h2, 8'h20, 1'b0, 4'h0);
        vt[5]  = mk(2'b11, 2'b11, 8'h21, 16'h2010, 2'b01, 2'b00, 8'h00, 1'b1, 4'h1, 8'h10, 1'b0, 4'h0);
        vt[6]  = mk(2'b11, 2'b11, 8'h21, 16'h2010, 2'b10, 2'b00, 8'h00, 1'b1, 4'h2, 8'h20, 1'b0, 4'h0);
        vt[7]  = mk(2'b01, 2'b01, 8'h03, 16'h00A5, 2'b01, 2'b00, 8'h00, 1'b1, 4'h3, 8'hA5, 1'b0, 4'h0);
        vt[8]  = mk(2'b00, 2'b00, 8'h00, 16'h0000, 2'b00, 2'b00, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0);
        vt[9]  = mk(2'b10, 2'b00, 8'h30, 16'h0000, 2'b10, 2'b00, 8'h00, 1'b0, 4'h0, 8'h00, 1'b1, 4'h3);
        vt[10] = mk(2'b00, 2'b00, 8'h00, 16'h0000, 2'b00, 2'b10, 8'hA5, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0);
        vt[11] = mk(2'b11, 2'b01, 8'h75, 16'h0011, 2'b11, 2'b00, 8'h00, 1'b1, 4'h5, 8'h11, 1'b1, 4'h7);
        vt[12] = mk(2'b00, 2'b00, 8'h00, 16'h0000, 2'b00, 2'b10, 8'h77, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0);
        vt[13] = mk(2'b01, 2'b00, 8'h01, 16'h0000, 2'b01, 2'b00, 8'h00, 1'b0, 4'h0, 8'h00, 1'b1, 4'h1);
        vt[14] = mk(2'b10, 2'b00, 8'h20, 16'h0000, 2'b10, 2'b01, 8'h10, 1'b0, 4'h0, 8'h00, 1'b1, 4'h2);
        vt[15] = mk(2'b01, 2'b00, 8'h05, 16'h0000, 2'b01, 2'b10, 8'h20, 1'b0, 4'h0, 8'h00, 1'b1, 4'h5);
        vt[16] = mk(2'b11, 2'b00, 8'h73, 16'h0000, 2'b10, 2'b01, 8'h11, 1'b0, 4'h0, 8'h00, 1'b1, 4'h7);
        vt[17] = mk(2'b01, 2'b00, 8'h03, 16'h0000, 2'b01, 2'b10, 8'h77, 1'b0, 4'h0, 8'h00, 1'b1, 4'h3);
        vt[18] = mk(2'b00, 2'b00, 8'h00, 16'h0000, 2'b00, 2'b01, 8'hA5, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0);

        rst_n = 1'b0;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        req_valid4 = '0; req_we4 = '0; req_addr4 = '0; req_wdata4 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_vec(vt[0], 0);
        chk("ready4_rst", 0, 32'(req_ready4), 32'd0);
        chk("rsp4_rst", 0, 32'(rsp_valid4), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int k = 0; k < 19; k++) apply_vec(vt[k], k);

        // Same-cycle write and read to address 4, which currently holds 0x00.
`ifdef EHGU_RAM_ARB_FWD_EN
        apply_vec(mk(2'b11, 2'b01, 8'h44, 16'h003C, 2'b11, 2'b00, 8'h00, 1'b1, 4'h4, 8'h3C, 1'b0, 4'h0), 100);
        apply_vec(mk(2'b00, 2'b00, 8'h00, 16'h0000, 2'b00, 2'b10, 8'h3C, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0), 101);
        apply_vec(mk(2'b00, 2'b00, 8'h00, 16'h0000, 2'b00, 2'b00, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0), 102);
`else
        apply_vec(mk(2'b11, 2'b01, 8'h44, 16'h003C, 2'b01, 2'b00, 8'h00, 1'b1, 4'h4, 8'h3C, 1'b0, 4'h0), 100);
        apply_vec(mk(2'b10, 2'b00, 8'h40, 16'h0000, 2'b10, 2'b00, 8'h00, 1'b0, 4'h0, 8'h00, 1'b1, 4'h4), 101);
        apply_vec(mk(2'b00, 2'b00, 8'h00, 16'h0000, 2'b00, 2'b10, 8'h3C, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0), 102);
`endif

        // Reset one cycle after a read accept; both pointers are non-zero here.
        apply_vec(mk(2'b01, 2'b00, 8'h03, 16'h0000, 2'b01, 2'b00, 8'h00, 1'b0, 4'h0, 8'h00, 1'b1, 4'h3), 200);
        req_valid = '0;
        rst_n = 1'b0;
        @(negedge clk);
        check_vec(vt[0], 201);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply_vec(vt[0], 202);
        apply_vec(mk(2'b11, 2'b11, 8'h98, 16'hA55A, 2'b01, 2'b00, 8'h00, 1'b1, 4'h8, 8'h5A, 1'b0, 4'h0), 203);
        apply_vec(mk(2'b11, 2'b00, 8'h98, 16'h0000, 2'b01, 2'b00, 8'h00, 1'b0, 4'h0, 8'h00, 1'b1, 4'h8), 204);
        apply_vec(mk(2'b00, 2'b00, 8'h00, 16'h0000, 2'b00, 2'b01, 8'h5A, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0), 205);

        // Four requesters reading continuously, requester i at address i.
        req_valid4 = 4'hF; req_we4 = 4'h0; req_addr4 = 16'h3210;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("ready4", 300 + k, 32'(req_ready4), 32'd1 << (k % 4));
            if (k > 0) begin
                chk("rsp_valid4", 300 + k, 32'(rsp_valid4), 32'd1 << ((k - 1) % 4));
                chk("rsp_data4", 300 + k, 32'(rsp_data4), 32'hC0 | 32'((k - 1) % 4));
            end
            @(posedge clk);
            #1;
        end
        req_valid4 = 4'h0;
        @(negedge clk);
        chk("ready4_idle", 306, 32'(req_ready4), 32'd0);
        chk("rsp_valid4", 306, 32'(rsp_valid4), 32'd2);
        chk("rsp_data4", 306, 32'(rsp_data4), 32'hC1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
